// File: rtl/dsp_ctrl_pkg.sv
// dsp_ctrl_pkg: shared state encoding and DSP slice opmode constants for the MAC sequencer.
package dsp_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] OPM_MUL_FIRST     = 8'h01;
  localparam logic [7:0] OPM_MUL_FIRST_SUB = 8'h81;
  localparam logic [7:0] OPM_MAC           = 8'h09;
  localparam logic [7:0] OPM_MAC_SUB       = 8'h89;
  localparam int PIPE_LAT = 3;
endpackage

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: two-stage valid/first tags that follow each accepted pair through the
// slice M and P registers, producing the matching enables and opmode.
module dsp_tag_pipe
  import dsp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       accept,
  input  logic       first,
  input  logic       sub,
  output logic       cem,
  output logic       ceopmode,
  output logic       cep,
  output logic [7:0] opmode
);
  logic v1, f1, v2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      v2 <= 1'b0;
    end else if (clr) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept;
      f1 <= accept && first;
      v2 <= v1;
    end
  end
  assign cem      = v1;
  assign ceopmode = v1;
  assign cep      = v2;
  // The first product overwrites P (Z=0); later ones add to or subtract from P.
  assign opmode = !v1 ? 8'h00
                : f1  ? (sub ? OPM_MUL_FIRST_SUB : OPM_MUL_FIRST)
                :       (sub ? OPM_MAC_SUB : OPM_MAC);
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams N operand pairs into one DSP slice as a +/- multiply-accumulate
// and hands the 48-bit P back over a valid/ready result port.
module dsp_mac_sequencer
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_start,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_sub,
  input  logic             job_abort,
  output logic             job_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_ce_ab,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ceopmode,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  output logic             dsp_rstm,
  input  logic [47:0]      dsp_p
);
  state_t state, state_nxt;
  logic [LEN_W-1:0] len, cnt;
  logic sub, accept;
  assign in_ready  = state == RUN && cnt < len && !job_abort;
  assign accept    = in_valid && in_ready;
  assign job_busy  = state != IDLE;
  assign res_valid = state == DONE;
  assign res_data  = dsp_p;
  assign dsp_a     = in_a;
  assign dsp_b     = in_b;
  assign dsp_ce_ab = accept;
  // Slice resets are synchronous, so hold them for as long as our async reset is low.
  assign dsp_rstp  = !rst_n || state == CLEAR || job_abort;
  assign dsp_rstm  = dsp_rstp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      sub   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (job_abort) begin
        cnt <= '0;
      end else if (state == IDLE && job_start) begin
        len <= job_len;
        sub <= job_sub;
        cnt <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (job_abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = job_start ? CLEAR : IDLE;
        CLEAR:   state_nxt = len == '0 ? DONE : RUN;
        RUN:     state_nxt = accept && cnt == len - 1'b1 ? DRAIN : RUN;
        DRAIN:   state_nxt = !dsp_cem && !dsp_cep ? DONE : DRAIN;
        DONE:    state_nxt = res_ready ? IDLE : DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end
  dsp_tag_pipe u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (job_abort),
    .accept   (accept),
    .first    (cnt == '0),
    .sub      (sub),
    .cem      (dsp_cem),
    .ceopmode (dsp_ceopmode),
    .cep      (dsp_cep),
    .opmode   (dsp_opmode)
  );
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: drives jobs through the sequencer against a behavioural DSP slice
// and checks results from a scoreboard of bench-computed sums.
module tb_dsp_mac_sequencer;
  import dsp_ctrl_pkg::*;
  localparam int LEN_W = 16;
  logic clk = 0, rst_n = 0;
  logic job_start = 0, job_sub = 0, job_abort = 0, job_busy;
  logic [LEN_W-1:0] job_len = '0;
  logic in_valid = 0, in_ready, res_valid, res_ready = 0;
  logic [17:0] in_a = '0, in_b = '0, dsp_a, dsp_b;
  logic [47:0] res_data, dsp_p;
  logic dsp_ce_ab, dsp_ceopmode, dsp_cem, dsp_cep, dsp_rstp, dsp_rstm;
  logic [7:0] dsp_opmode;
  logic [17:0] a1 = '0, b1 = '0;
  logic [35:0] m = '0;
  logic [7:0] opm_r = '0;
  logic [47:0] p = '0;
  int checks = 0, errors = 0, cyc = 0, cep_count = 0;
  bit ir_seen = 0;
  logic [47:0] sb_q[$];

  always #5 clk = ~clk;

  dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .job_len(job_len), .job_sub(job_sub),
    .job_abort(job_abort), .job_busy(job_busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce_ab(dsp_ce_ab), .dsp_opmode(dsp_opmode),
    .dsp_ceopmode(dsp_ceopmode), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
    .dsp_rstp(dsp_rstp), .dsp_rstm(dsp_rstm), .dsp_p(dsp_p)
  );

  // Behavioural slice: A1/B1 -> M -> P with registered opmode, sync resets winning over CE.
  always @(posedge clk) begin
    if (dsp_ce_ab) begin
      a1 <= dsp_a;
      b1 <= dsp_b;
    end
    if (dsp_rstm) m <= '0;
    else if (dsp_cem) m <= 36'($signed(a1) * $signed(b1));
    if (dsp_ceopmode) opm_r <= dsp_opmode;
    if (dsp_rstp) p <= '0;
    else if (dsp_cep)
      p <= opm_r[7] ? (opm_r[3:2] == 2'b10 ? p : 48'd0) - {{12{m[35]}}, m}
                    : (opm_r[3:2] == 2'b10 ? p : 48'd0) + {{12{m[35]}}, m};
  end
  assign dsp_p = p;

  always @(posedge clk) begin
    cyc++;
    cep_count += int'(dsp_cep);
    if (in_ready) ir_seen = 1;
  end

  task automatic start_job(input int len, input bit sub);
    @(negedge clk);
    job_start = 1;
    job_len = LEN_W'(len);
    job_sub = sub;
    @(negedge clk);
    job_start = 0;
  endtask

  task automatic send_pair(input int a, input int b, output int acc_edge);
    in_a = 18'(a);
    in_b = 18'(b);
    in_valid = 1;
    acc_edge = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready) begin
        @(negedge clk);
        in_valid = 0;
        acc_edge = cyc;
        return;
      end
      @(negedge clk);
    end
    in_valid = 0;
    checks++;
    errors++;
    $display("FAIL accept_timeout: pair (%0d,%0d) not accepted, required acceptance within 40 cycles", a, b);
  endtask

  task automatic wait_result(output int edge_n);
    edge_n = -1;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        edge_n = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL result_timeout: res_valid never rose, required within 50 cycles");
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({job_busy, in_ready, res_valid, dsp_ce_ab, dsp_cem, dsp_ceopmode, dsp_cep} !== 7'b0 || dsp_opmode !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rdy=%b rv=%b ce=%b%b%b%b opm=%h, required all 0", job_busy, in_ready,
               res_valid, dsp_ce_ab, dsp_cem, dsp_ceopmode, dsp_cep, dsp_opmode);
    end
    checks++;
    if ({dsp_rstp, dsp_rstm} !== 2'b11) begin
      errors++;
      $display("FAIL reset_rst: rstp=%b rstm=%b, required 1 1", dsp_rstp, dsp_rstm);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({job_busy, dsp_rstp, dsp_rstm} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: busy=%b rstp=%b rstm=%b, required 0 0 0", job_busy, dsp_rstp, dsp_rstm);
    end
  endtask

  task automatic test_basic();
    int pa[4] = '{1, 3, 5, 7};
    int pb[4] = '{2, 4, 6, 8};
    longint sum = 0;
    int acc, e;
    logic [47:0] expv;
    for (int i = 0; i < 4; i++) sum += longint'(pa[i]) * pb[i];
    sb_q.push_back(48'(sum));
    start_job(4, 0);
    for (int i = 0; i < 4; i++) send_pair(pa[i], pb[i], acc);
    in_valid = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_extra_pair: in_ready=%b after 4 accepts, required 0", in_ready);
    end
    in_valid = 0;
    wait_result(e);
    checks++;
    if (e - acc !== PIPE_LAT) begin
      errors++;
      $display("FAIL basic_latency: res_valid %0d edges after last accept, required %0d", e - acc, PIPE_LAT);
    end
    expv = sb_q.pop_front();
    checks++;
    if (res_data !== expv) begin
      errors++;
      $display("FAIL basic_result: res_data=%0d, required %0d", res_data, expv);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    checks++;
    if (job_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: job_busy=%b after consume, required 0", job_busy);
    end
  endtask

  task automatic test_sub_bubbles();
    int pa[3] = '{10, 2, -1};
    int pb[3] = '{10, 3, 5};
    longint sum = 0;
    int acc, e;
    logic [47:0] expv;
    for (int i = 0; i < 3; i++) sum -= longint'(pa[i]) * pb[i];
    sb_q.push_back(48'(sum));
    start_job(3, 1);
    cep_count = 0;
    for (int i = 0; i < 3; i++) begin
      send_pair(pa[i], pb[i], acc);
      repeat (2) @(negedge clk);
    end
    wait_result(e);
    expv = sb_q.pop_front();
    checks++;
    if (res_data !== expv) begin
      errors++;
      $display("FAIL sub_result: res_data=%h, required %h", res_data, expv);
    end
    checks++;
    if (cep_count !== 3) begin
      errors++;
      $display("FAIL sub_cep_pulses: %0d, required 3", cep_count);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_zero_len();
    logic [47:0] expv;
    sb_q.push_back(48'd0);
    ir_seen = 0;
    start_job(0, 0);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear: res_valid=%b in CLEAR, required 0", res_valid);
    end
    @(negedge clk);
    expv = sb_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== expv) begin
      errors++;
      $display("FAIL zero_done: res_valid=%b res_data=%0d, required 1 and %0d", res_valid, res_data, expv);
    end
    checks++;
    if (ir_seen) begin
      errors++;
      $display("FAIL zero_in_ready: in_ready asserted=%b, required 0", ir_seen);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_hold();
    int acc, e;
    logic [47:0] expv;
    sb_q.push_back(48'(longint'(100) * -7 + longint'(-3) * -3));
    start_job(2, 0);
    send_pair(100, -7, acc);
    send_pair(-3, -3, acc);
    wait_result(e);
    expv = sb_q.pop_front();
    job_start = 1;
    job_len = 7;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== expv || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: rv=%b data=%0d rdy=%b, required 1 %0d 0", i, res_valid, res_data, in_ready, expv);
      end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    job_start = 0;
    res_ready = 0;
    #1;
    checks++;
    if (job_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: job_busy=%b, required 0 (start ignored in DONE)", job_busy);
    end
  endtask

  task automatic test_abort();
    int acc, e;
    logic [47:0] expv;
    start_job(5, 0);
    send_pair(20, 20, acc);
    send_pair(30, 30, acc);
    job_abort = 1;
    in_valid = 1;
    #1;
    checks++;
    if (dsp_rstp !== 1'b1 || dsp_rstm !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: rstp=%b rstm=%b rdy=%b, required 1 1 0", dsp_rstp, dsp_rstm, in_ready);
    end
    @(negedge clk);
    job_abort = 0;
    in_valid = 0;
    #1;
    checks++;
    if (job_busy !== 1'b0 || dsp_rstp !== 1'b0 || dsp_cep !== 1'b0 || dsp_cem !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b rstp=%b cep=%b cem=%b, required 0 0 0 0", job_busy, dsp_rstp, dsp_cep, dsp_cem);
    end
    sb_q.push_back(48'd9);
    start_job(1, 0);
    send_pair(3, 3, acc);
    wait_result(e);
    expv = sb_q.pop_front();
    checks++;
    if (res_data !== expv) begin
      errors++;
      $display("FAIL abort_next_job: res_data=%0d, required %0d", res_data, expv);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_async_reset();
    int acc, e;
    logic [47:0] expv;
    start_job(4, 0);
    send_pair(4, 4, acc);
    in_valid = 1;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({job_busy, in_ready, res_valid, dsp_ce_ab, dsp_cem, dsp_ceopmode, dsp_cep} !== 7'b0 || dsp_opmode !== 8'h00 ||
        {dsp_rstp, dsp_rstm} !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: busy=%b rdy=%b rv=%b ce=%b%b%b%b opm=%h rst=%b%b, required 0s and rst 11", job_busy,
               in_ready, res_valid, dsp_ce_ab, dsp_cem, dsp_ceopmode, dsp_cep, dsp_opmode, dsp_rstp, dsp_rstm);
    end
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (job_busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_release: busy=%b rdy=%b, required 0 0", job_busy, in_ready);
    end
    sb_q.push_back(48'd14);
    start_job(1, 1);
    send_pair(-2, 7, acc);
    wait_result(e);
    expv = sb_q.pop_front();
    checks++;
    if (res_data !== expv) begin
      errors++;
      $display("FAIL async_next_job: res_data=%0d, required %0d", res_data, expv);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub_bubbles();
    test_zero_len();
    test_hold();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controls one DSP slice (18x18 multiplier, registered post-adder, 48-bit P) as a streaming multiply-accumulate engine.
- A job carries a length N and an add/subtract mode. The block accepts N operand pairs over a valid/ready stream.
- It drives the slice's operand, opmode, clock-enable and reset pins so that P = ±sum(a_i*b_i). It then returns P over a valid/ready result port.
- It sits between the stream fabric and the DSP instance. The slice is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, RSTTYPE="SYNC", B_INPUT="DIRECT".

Parameters:
- LEN_W, 16, width of job_len; max job is 2^LEN_W-1 pairs.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  start pulse; sampled only in IDLE
- job_len  in  LEN_W  number of operand pairs N
- job_sub  in  1  0: accumulate +a*b; 1: accumulate -a*b
- job_abort  in  1  abandon the current job from any state
- job_busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts the pair
- in_a  in  18  operand A
- in_b  in  18  operand B
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  48  accumulated result (equals dsp_p)
- dsp_a, dsp_b  out  18  to slice A, B (combinational copies of in_a, in_b)
- dsp_ce_ab  out  1  to CEA and CEB
- dsp_opmode  out  8  to slice opmode input
- dsp_ceopmode, dsp_cem, dsp_cep  out  1  slice enables
- dsp_rstp, dsp_rstm  out  1  slice synchronous resets, active-high
- dsp_p  in  48  slice P output

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and all tag pipeline bits clear.
  - Outputs: job_busy=0, in_ready=0, res_valid=0, all dsp_ce*=0, dsp_opmode=0. dsp_rstp=1 and dsp_rstm=1 while reset is held.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - job_start=1 latches len and sub, zeroes the counter and goes to CLEAR.
- CLEAR (1 cycle):
  - dsp_rstp=1 and dsp_rstm=1.
  - If len==0, go to DONE; the result is 0. Otherwise go to RUN.
- RUN:
  - in_ready = (cnt < len).
  - Accept = in_valid & in_ready. On accept, dsp_ce_ab=1 and cnt increments.
  - When the accepted pair is number len, go to DRAIN.
- Tag pipeline:
  - Stage 1 gets v1 <= accept and f1 <= (cnt==0).
  - Stage 2 gets v2 <= v1.
- dsp_cem = dsp_ceopmode = v1, so the product and its opmode load together.
- dsp_cep = v2, so the post-adder consumes exactly one product per accepted pair. Input bubbles never double-count.
- dsp_opmode is driven while v1=1:
  - First pair (f1=1): 8'h01, or 8'h81 when sub=1.
  - Other pairs: 8'h09, or 8'h89 when sub=1.
  - opmode[6:4] is always 0: no pre-adder, carry-in 0.
- Latency: a pair accepted in cycle t appears in P from cycle t+3. Throughput is one pair per cycle.
- DRAIN: wait until v1=0 and v2=0, then go to DONE. res_valid rises the cycle after the last P update.
- DONE:
  - res_valid=1 and res_data=dsp_p, held stable because CEP stays low.
  - res_valid & res_ready returns to IDLE.
  - A job_start in the same cycle is ignored; it must be re-issued in IDLE.
- Abort:
  - job_abort=1 in any state goes to IDLE and clears v1, v2 and cnt.
  - It pulses dsp_rstp and dsp_rstm for one cycle. No result is produced.
  - Abort has priority over every other event in that cycle.
- Overflow: P wraps modulo 2^48 with no saturation. This is the slice's behaviour.
- in_ready is 0 in every state except RUN. Extra pairs beyond len are never accepted.

Decomposition:
- Shared package dsp_ctrl_pkg holds:
  - state enum
  - constants OPM_MUL_FIRST=8'h01, OPM_MUL_FIRST_SUB=8'h81, OPM_MAC=8'h09, OPM_MAC_SUB=8'h89
  - constant PIPE_LAT=3
- One sub-module: dsp_tag_pipe, the 2-stage valid/first tag shift register that generates cem, ceopmode, cep and opmode.

Test Plan:
- len=4, sub=0, pairs (1,2),(3,4),(5,6),(7,8) with no bubbles -> res_data=100, res_valid 3 cycles after the last accept, in_ready low after 4 accepts.
- len=3, sub=1, pairs (10,10),(2,3),(-1,5) with in_valid bubbles between each pair -> res_data=-101 (48-bit two's complement), dsp_cep pulses exactly 3 times.
- len=0 -> DONE two cycles after job_start with res_data=0; in_ready never asserts.
- len=2 result held with res_ready=0 for 10 cycles -> res_data stable, job_start ignored, in_ready=0; then res_ready=1 -> IDLE next cycle.
- Abort after 2 of 5 pairs -> IDLE, dsp_rstp pulses; a new len=1 job with (3,3) returns 9.
- rst_n asserted mid-RUN -> all outputs reach their reset values immediately; after release the sequencer is in IDLE with job_busy=0.
